// File: rtl/assert_result_arbiter.sv
// Shares one valid/ready result-report port among N_CH assertion checkers.
// Each channel keeps a one-entry pending slot and a saturating fail counter; a round-robin grant drains the slots.

module assert_result_arbiter_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             match,
  input  logic             fail,
  input  logic             gnt,
  output logic             pend,
  output logic             pend_pass,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);
  logic ev;
  assign ev = match | fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_pass <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
    end else begin
      // A slot granted on this edge is free to take a new event on the same edge.
      if (!pend || gnt) begin
        pend <= ev;
        if (ev) pend_pass <= !fail;
      end
      if (clr) begin
        ovf <= 1'b0;
        cnt <= '0;
      end else begin
        if (ev && pend && !gnt) ovf <= 1'b1;
        if (fail && cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module assert_result_arbiter #(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       chk_match,
  input  logic [N_CH-1:0]       chk_fail,
  input  logic                  clr,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [CH_W-1:0]       rpt_ch,
  output logic                  rpt_pass,
  output logic [N_CH-1:0]       overflow,
  output logic [N_CH*CNT_W-1:0] fail_cnt
);
  logic [N_CH-1:0] pend, pend_pass, gnt_oh;
  logic [CH_W-1:0] rr_ptr, gnt_idx, idx;
  logic            gnt_any, free, gnt;

  assign free = !rpt_valid || rpt_ready;
  assign gnt  = free && gnt_any;

  // Scan from the highest offset down so the channel nearest rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      idx = CH_W'((int'(rr_ptr) + k) % N_CH);
      if (pend[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign gnt_oh[i] = gnt && (gnt_idx == CH_W'(i));
    assert_result_arbiter_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .match     (chk_match[i]),
      .fail      (chk_fail[i]),
      .gnt       (gnt_oh[i]),
      .pend      (pend[i]),
      .pend_pass (pend_pass[i]),
      .ovf       (overflow[i]),
      .cnt       (fail_cnt[i*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_valid <= 1'b0;
      rpt_ch    <= '0;
      rpt_pass  <= 1'b0;
      rr_ptr    <= '0;
    end else if (free) begin
      rpt_valid <= gnt_any;
      if (gnt_any) begin
        rpt_ch   <= gnt_idx;
        rpt_pass <= pend_pass[gnt_idx];
        rr_ptr   <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_assert_result_arbiter.sv
// Bench for assert_result_arbiter: directed table, hand sequences, then random traffic vs a reference model.

module tb_assert_result_arbiter;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     chk_match, chk_fail;
  logic             clr, rpt_ready;
  logic             rpt_valid, rpt_pass;
  logic [1:0]       rpt_ch;
  logic [N-1:0]     overflow;
  logic [N*CNT_W-1:0] fail_cnt;

  int checks = 0;
  int failures = 0;

  assert_result_arbiter #(.N_CH(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .chk_match(chk_match), .chk_fail(chk_fail), .clr(clr),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_ch(rpt_ch), .rpt_pass(rpt_pass),
    .overflow(overflow), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: slots, output register and pointer as plain arrays/ints.
  bit m_pend[N];
  bit m_ppass[N];
  bit m_ovf[N];
  int m_cnt[N];
  bit m_v, m_pass;
  int m_ch, m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_ppass[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
    end
    m_v = 0; m_pass = 0; m_ch = 0; m_ptr = 0;
  endfunction

  function automatic void model_step(bit [N-1:0] mt, bit [N-1:0] ft, bit c, bit r, bit rs);
    bit free;
    int g;
    if (!rs) begin
      model_reset();
      return;
    end
    free = !m_v || r;
    g = -1;
    if (free) begin
      for (int j = 0; j < N; j++)
        if (g < 0 && m_pend[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      m_v = (g >= 0);
      if (g >= 0) begin
        m_ch = g; m_pass = m_ppass[g]; m_ptr = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (c) begin
        m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (ft[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      if (mt[i] || ft[i]) begin
        if (!m_pend[i] || g == i) begin
          m_pend[i] = 1; m_ppass[i] = !ft[i];
        end else if (!c) m_ovf[i] = 1;
      end else if (g == i) m_pend[i] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] mt, input logic [N-1:0] ft, input logic c,
                      input logic r, input logic rs);
    logic [N-1:0] e_ovf;
    logic [N*CNT_W-1:0] e_cnt;
    chk_match = mt; chk_fail = ft; clr = c; rpt_ready = r; rst_n = rs;
    model_step(mt, ft, c, r, rs);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      e_ovf[i] = m_ovf[i];
      e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    end
    chk("model_valid", 64'(rpt_valid), 64'(m_v));
    chk("model_ch", 64'(rpt_ch), 64'(m_ch));
    chk("model_pass", 64'(rpt_pass), 64'(m_pass));
    chk("model_overflow", 64'(overflow), 64'(e_ovf));
    chk("model_fail_cnt", 64'(fail_cnt), 64'(e_cnt));
  endtask

  function automatic int cnt_of(int ch);
    logic [N*CNT_W-1:0] v;
    v = fail_cnt;
    return int'(v[ch*CNT_W +: CNT_W]);
  endfunction

  typedef struct {
    logic       rs;
    logic [3:0] m;
    logic [3:0] f;
    logic       r;
    logic       ev;
    logic [1:0] ech;
    logic       ep;
  } vec_t;

  vec_t tbl[20];

  initial begin
    chk_match = '0; chk_fail = '0; clr = 0; rpt_ready = 1; rst_n = 0;
    model_reset();
    step('0, '0, 0, 1, 0);
    step('0, '0, 0, 1, 0);
    chk("reset_valid", 64'(rpt_valid), 64'd0);
    chk("reset_cnt", 64'(fail_cnt), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);

    // Single event on ch2, then reset and two rounds of all-channel matches.
    for (int i = 0; i < 5; i++) tbl[i] = '{1, 4'h0, 4'h0, 1, 0, 2'd0, 0};
    tbl[5]  = '{1, 4'h0, 4'h4, 1, 0, 2'd0, 0};
    tbl[6]  = '{1, 4'h0, 4'h0, 1, 1, 2'd2, 0};
    tbl[7]  = '{1, 4'h0, 4'h0, 1, 0, 2'd0, 0};
    tbl[8]  = '{0, 4'h0, 4'h0, 1, 0, 2'd0, 0};
    tbl[9]  = '{1, 4'hF, 4'h0, 1, 0, 2'd0, 0};
    tbl[10] = '{1, 4'h0, 4'h0, 1, 1, 2'd0, 1};
    tbl[11] = '{1, 4'h0, 4'h0, 1, 1, 2'd1, 1};
    tbl[12] = '{1, 4'h0, 4'h0, 1, 1, 2'd2, 1};
    tbl[13] = '{1, 4'h0, 4'h0, 1, 1, 2'd3, 1};
    tbl[14] = '{1, 4'hF, 4'h0, 1, 0, 2'd0, 0};
    tbl[15] = '{1, 4'h0, 4'h0, 1, 1, 2'd0, 1};
    tbl[16] = '{1, 4'h0, 4'h0, 1, 1, 2'd1, 1};
    tbl[17] = '{1, 4'h0, 4'h0, 1, 1, 2'd2, 1};
    tbl[18] = '{1, 4'h0, 4'h0, 1, 1, 2'd3, 1};
    tbl[19] = '{1, 4'h0, 4'h0, 1, 0, 2'd0, 0};
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].m, tbl[i].f, 0, tbl[i].r, tbl[i].rs);
      chk($sformatf("tbl%0d_valid", i), 64'(rpt_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_ch", i), 64'(rpt_ch), 64'(tbl[i].ech));
        chk($sformatf("tbl%0d_pass", i), 64'(rpt_pass), 64'(tbl[i].ep));
      end
      if (i == 7) chk("single_cnt2", 64'(cnt_of(2)), 64'd1);
    end

    // Backpressure: three ch1 matches with ready low; the third is dropped.
    step('0, '0, 0, 1, 0);
    step(4'h2, '0, 0, 0, 1);
    chk("bp_c0_valid", 64'(rpt_valid), 64'd0);
    step(4'h2, '0, 0, 0, 1);
    chk("bp_c1_valid", 64'(rpt_valid), 64'd1);
    chk("bp_c1_ch", 64'(rpt_ch), 64'd1);
    chk("bp_c1_pass", 64'(rpt_pass), 64'd1);
    chk("bp_c1_ovf", 64'(overflow), 64'd0);
    step(4'h2, '0, 0, 0, 1);
    chk("bp_c2_ovf", 64'(overflow), 64'h2);
    step('0, '0, 0, 0, 1);
    chk("bp_hold_valid", 64'(rpt_valid), 64'd1);
    chk("bp_hold_ch", 64'(rpt_ch), 64'd1);
    step('0, '0, 0, 1, 1);
    chk("bp_second_valid", 64'(rpt_valid), 64'd1);
    chk("bp_second_ch", 64'(rpt_ch), 64'd1);
    step('0, '0, 0, 1, 1);
    chk("bp_drained", 64'(rpt_valid), 64'd0);

    // Match and fail together on ch3 is one fail report.
    step('0, '0, 0, 1, 0);
    step(4'h8, 4'h8, 0, 1, 1);
    step('0, '0, 0, 1, 1);
    chk("mf_valid", 64'(rpt_valid), 64'd1);
    chk("mf_ch", 64'(rpt_ch), 64'd3);
    chk("mf_pass", 64'(rpt_pass), 64'd0);
    chk("mf_cnt3", 64'(cnt_of(3)), 64'd1);
    step('0, '0, 0, 1, 1);
    chk("mf_single", 64'(rpt_valid), 64'd0);

    // Saturation, then clr alongside a fail with overflow set beforehand.
    for (int i = 0; i < 300; i++) step(4'h0, 4'h1, 0, 1, 1);
    chk("sat_cnt0", 64'(cnt_of(0)), 64'(MAXC));
    chk("sat_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) step('0, '0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(4'h2, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step('0, '0, 0, 1, 1);
    chk("pre_clr_ovf", 64'(overflow), 64'h2);
    chk("pre_clr_cnt0", 64'(cnt_of(0)), 64'(MAXC));
    step('0, 4'h1, 1, 1, 1);
    chk("clr_cnt0", 64'(cnt_of(0)), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    step('0, '0, 0, 1, 1);
    chk("clr_rpt_valid", 64'(rpt_valid), 64'd1);
    chk("clr_rpt_ch", 64'(rpt_ch), 64'd0);
    chk("clr_rpt_pass", 64'(rpt_pass), 64'd0);

    // Reset with a report in flight and slots pending.
    step('0, 4'hF, 0, 0, 1);
    step('0, 4'hF, 0, 0, 1);
    chk("pre_rst_valid", 64'(rpt_valid), 64'd1);
    step('0, '0, 0, 0, 0);
    chk("rst_valid", 64'(rpt_valid), 64'd0);
    chk("rst_cnt", 64'(fail_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step('0, '0, 0, 1, 1);
      chk("rst_no_stale", 64'(rpt_valid), 64'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] mt, ft;
      for (int b = 0; b < N; b++) begin
        mt[b] = ($urandom_range(0, 3) == 0);
        ft[b] = ($urandom_range(0, 4) == 0);
      end
      step(mt, ft, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
